// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcodes and FSM states shared by the pipeline hazard logic.
package hazard_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {RUN = 2'd0, LU2 = 2'd1, MD = 2'd2} hazardState_t;
endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubbles, branch squash and mult/div front-end hold for the pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] IFID_Instruction,
    input  logic        IDEXE_MemRead,
    input  logic        IDEXE_WriteEnable,
    input  logic [4:0]  IDEXE_WriteRegister,
    input  logic        BranchTaken,
    input  logic        MulDivStart,
    output logic        PCStall,
    output logic        IFIDStall,
    output logic        IFIDFlush,
    output logic        IDEXEStall,
    output logic        IDEXEFlush,
    output logic        EXEMEMFlush,
    output logic        Busy
);
    localparam int CNT_W = $clog2(MULDIV_CYCLES);

    hazardState_t     state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             usesRt;
    logic             isBranch;
    logic             dep;
    logic             mdStall;
    logic             bubble;

    always_comb begin
        opcode   = IFID_Instruction[31:26];
        rs       = IFID_Instruction[25:21];
        rt       = IFID_Instruction[20:16];
        isBranch = opcode == OP_BEQ || opcode == OP_BNE;
        usesRt   = opcode == OP_RTYPE || isBranch || opcode == OP_SW;
        dep      = IDEXE_WriteEnable && IDEXE_WriteRegister != 5'd0 &&
                   (IDEXE_WriteRegister == rs || (usesRt && IDEXE_WriteRegister == rt));
        mdStall  = (state == RUN && MulDivStart) || (state == MD && cnt != '0);
        bubble   = state == LU2 ||
                   (state == RUN && !MulDivStart && dep && (IDEXE_MemRead || isBranch));
    end

    // RESET gates every output so nothing stalls while the pipe is held in reset
    assign PCStall     = RESET && (mdStall || bubble);
    assign IFIDStall   = RESET && (mdStall || bubble);
    assign IDEXEStall  = RESET && mdStall;
    assign EXEMEMFlush = RESET && mdStall;
    assign IDEXEFlush  = RESET && bubble;
    assign IFIDFlush   = RESET && state == RUN && !MulDivStart && !bubble && BranchTaken;
    assign Busy        = RESET && state == MD;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (MulDivStart) begin
                        state <= MD;
                        cnt   <= CNT_W'(MULDIV_CYCLES - 2);
                    end else if (dep && IDEXE_MemRead && isBranch) begin
                        state <= LU2;
                    end
                end
                LU2: state <= RUN;
                MD: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
